// File: rtl/histogram_reader.sv
// ----------------------------------------------------------------------------
// histogram_reader
//
// Purpose
//   Read-out and clear side of the pixel histogram. A rising edge on VSYNC
//   starts one sweep over all 2**DATA_WIDTH bins of the count RAM. Each bin is
//   read, presented downstream as (BinIndex, BinCount) over valid/ready, and
//   cleared in the RAM in the same cycle it is accepted. The RAM is therefore
//   clean for the next frame's accumulation when the sweep ends.
//
// Build option
//   HIST_CDF_EN : when defined, BinCount carries the saturating running sum of
//                 the bins read so far (cumulative histogram). Ports and timing
//                 are the same in both builds.
//
// Ports
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           synchronous reset, active low
//   VSYNC      in   1           frame sync, rising edge starts a sweep
//   RamAddr    out  DATA_WIDTH  RAM read / clear address
//   RamRdData  in   CNT_WIDTH   RAM read data, one cycle after RamAddr
//   RamClrEn   out  1           write zero to RamAddr this cycle
//   BinValid   out  1           BinIndex / BinCount valid
//   BinReady   in   1           downstream accepts the bin
//   BinIndex   out  DATA_WIDTH  bin being presented
//   BinCount   out  CNT_WIDTH   bin count (cumulative with HIST_CDF_EN)
//   Busy       out  1           sweep in progress
//   FrameDone  out  1           one-cycle pulse after the last bin is accepted
//   Overrun    out  1           one-cycle pulse: VSYNC rise dropped while active
// ----------------------------------------------------------------------------
module histogram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  VSYNC,
    output logic [DATA_WIDTH-1:0] RamAddr,
    input  logic [CNT_WIDTH-1:0]  RamRdData,
    output logic                  RamClrEn,
    output logic                  BinValid,
    input  logic                  BinReady,
    output logic [DATA_WIDTH-1:0] BinIndex,
    output logic [CNT_WIDTH-1:0]  BinCount,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  Overrun
);

    typedef enum logic [2:0] {
        IDLE,
        RD,     // address presented to the RAM
        LAT,    // read data arrives, captured at the end of this cycle
        OUT,    // bin presented downstream
        DONE    // frame-done pulse
    } stateType;

    localparam logic [DATA_WIDTH-1:0] LAST_BIN = '1;

    stateType              stateReg;
    stateType              stateNext;
    logic                  vsD;
    logic                  start;
    logic                  lastBin;
    logic                  accept;
    logic [DATA_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  countReg;
    logic [CNT_WIDTH-1:0]  countNext;

    assign start   = VSYNC & ~vsD;
    assign lastBin = (addr == LAST_BIN);
    assign accept  = (stateReg == OUT) & BinReady;

`ifdef HIST_CDF_EN
    // countReg doubles as the running sum: it is cleared at start and each new
    // bin is added on top of the previously presented total.
    logic [CNT_WIDTH:0] sumWide;

    assign sumWide   = {1'b0, countReg} + {1'b0, RamRdData};
    assign countNext = sumWide[CNT_WIDTH] ? '1 : sumWide[CNT_WIDTH-1:0];
`else
    assign countNext = RamRdData;
`endif

    // State register.
    // NOTE: sequential logic uses non-blocking assignments so every register
    // updates from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Datapath registers. addr stops at the last bin; the sweep ends on the
    // last-bin compare rather than on a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsD      <= 1'b0;
            addr     <= '0;
            countReg <= '0;
        end else begin
            vsD <= VSYNC;
            if (stateReg == IDLE && start) begin
                addr     <= '0;
                countReg <= '0;
            end
            if (stateReg == LAT) begin
                countReg <= countNext;
            end
            if (accept && !lastBin) begin
                addr <= addr + 1'b1;
            end
        end
    end

    // Next-state logic. A start outside IDLE is dropped, never queued.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = RD;
            RD:      stateNext = LAT;
            LAT:     stateNext = OUT;
            OUT:     if (accept) stateNext = lastBin ? DONE : RD;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic. RamAddr stays on addr through RD, LAT and OUT so the
    // clear in OUT hits exactly the word that was read.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        RamAddr   = '0;
        RamClrEn  = 1'b0;
        BinValid  = 1'b0;
        BinIndex  = '0;
        BinCount  = '0;
        Busy      = 1'b0;
        FrameDone = 1'b0;
        Overrun   = start & (stateReg != IDLE);
        case (stateReg)
            RD, LAT: begin
                Busy    = 1'b1;
                RamAddr = addr;
            end
            OUT: begin
                Busy     = 1'b1;
                RamAddr  = addr;
                BinValid = 1'b1;
                BinIndex = addr;
                BinCount = countReg;
                RamClrEn = BinReady;
            end
            DONE: begin
                FrameDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_histogram_reader.sv
// ----------------------------------------------------------------------------
// tb_histogram_reader
//
// Directed bench for histogram_reader. A behavioural RAM (one-cycle read,
// zero-write on RamClrEn) is preloaded with a small histogram; expected bin
// values come from that preload table, accumulated with saturation when the
// design is built with HIST_CDF_EN.
// ----------------------------------------------------------------------------
module tb_histogram_reader;

    localparam int              DW    = 8;
    localparam int              CW    = 18;
    localparam int              NBINS = 1 << DW;
    localparam logic [CW-1:0]   MAXC  = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          VSYNC;
    logic [DW-1:0] RamAddr;
    logic [CW-1:0] RamRdData;
    logic          RamClrEn;
    logic          BinValid;
    logic          BinReady;
    logic [DW-1:0] BinIndex;
    logic [CW-1:0] BinCount;
    logic          Busy;
    logic          FrameDone;
    logic          Overrun;

    always #5 clk = ~clk;

    histogram_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .VSYNC     (VSYNC),
        .RamAddr   (RamAddr),
        .RamRdData (RamRdData),
        .RamClrEn  (RamClrEn),
        .BinValid  (BinValid),
        .BinReady  (BinReady),
        .BinIndex  (BinIndex),
        .BinCount  (BinCount),
        .Busy      (Busy),
        .FrameDone (FrameDone),
        .Overrun   (Overrun)
    );

    // Histogram RAM model.
    logic [CW-1:0] mem    [NBINS];
    logic [CW-1:0] pre    [NBINS];
    logic [CW-1:0] expCnt [NBINS];

    always @(posedge clk) begin
        RamRdData <= mem[RamAddr];
        if (RamClrEn) mem[RamAddr] = '0;
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic set_preload(input bit sat);
        for (int i = 0; i < NBINS; i++) pre[i] = '0;
        if (sat) begin
            pre[0] = MAXC;
            pre[1] = 18'd5;
        end else begin
            pre[0] = 18'd1; pre[1] = 18'd3; pre[2] = 18'd2; pre[3] = 18'd1;
            pre[4] = 18'd2; pre[5] = 18'd3; pre[6] = 18'd4;
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < NBINS; i++) mem[i] = pre[i];
    endtask

    task automatic build_exp();
        logic [CW:0] acc;
        acc = '0;
        for (int i = 0; i < NBINS; i++) begin
`ifdef HIST_CDF_EN
            acc = acc + {1'b0, pre[i]};
            if (acc > {1'b0, MAXC}) acc = {1'b0, MAXC};
            expCnt[i] = acc[CW-1:0];
`else
            expCnt[i] = pre[i];
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {BinValid, Busy, FrameDone, Overrun, RamClrEn, RamAddr, BinIndex, BinCount}, 64'd0);
    endtask

    // Per-sweep observations.
    int nAcc, nClr, nDone, nOvr, badBins, stallErr, clrAddrErr, firstValid, doneCyc;
    bit timedOut;

    // One full sweep: VSYNC low for a cycle, then rising. Cycle 1 is the cycle
    // after the edge that samples the rise.
    task automatic run_sweep(input bit randReady, input int ovBin, input bit holdVs, input bit verbose);
        bit            stalled;
        bit            ovDone;
        logic [DW-1:0] sIdx;
        logic [CW-1:0] sCnt;
        int            cyc;
        int            post;
        nAcc = 0; nClr = 0; nDone = 0; nOvr = 0; badBins = 0; stallErr = 0;
        clrAddrErr = 0; firstValid = -1; doneCyc = -1;
        stalled = 1'b0; ovDone = 1'b0; sIdx = '0; sCnt = '0; post = 0;
        @(negedge clk); VSYNC = 1'b0; BinReady = 1'b0;
        @(negedge clk); VSYNC = 1'b1;
        cyc = 0;
        while (cyc < 5000 && post < 4) begin
            @(negedge clk);
            cyc++;
            #1;
            if (FrameDone) begin
                nDone++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (nDone > 0) post++;
            if (BinValid && firstValid < 0) firstValid = cyc;
            if (BinValid && stalled && (BinIndex !== sIdx || BinCount !== sCnt)) stallErr++;
            BinReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!holdVs && cyc == 4) VSYNC = 1'b0;
            if (ovBin >= 0 && !ovDone && BinValid && BinIndex == ovBin[DW-1:0]) begin
                VSYNC  = 1'b1;
                ovDone = 1'b1;
            end
            #1;
            if (Overrun) nOvr++;
            if (RamClrEn) begin
                nClr++;
                if (RamAddr !== BinIndex) clrAddrErr++;
            end
            stalled = BinValid && !BinReady;
            sIdx    = BinIndex;
            sCnt    = BinCount;
            if (BinValid && BinReady) begin
                if (verbose && (nAcc < 8 || nAcc == NBINS - 1)) begin
                    check($sformatf("bin%0d_index", nAcc), BinIndex, nAcc);
                    check($sformatf("bin%0d_count", nAcc), BinCount, expCnt[nAcc]);
                end
                if (nAcc >= NBINS || BinIndex !== nAcc[DW-1:0] || BinCount !== expCnt[nAcc]) badBins++;
                nAcc++;
            end
        end
        timedOut = (nDone == 0);
    endtask

    task automatic check_sweep(input string tag, input int expOvr, input int expDoneCyc);
        int nz;
        nz = 0;
        for (int i = 0; i < NBINS; i++) if (mem[i] !== '0) nz++;
        check({tag, "_timeout"},   timedOut,   0);
        check({tag, "_latency"},   firstValid, 3);
        check({tag, "_accepted"},  nAcc,       NBINS);
        check({tag, "_cleared"},   nClr,       NBINS);
        check({tag, "_framedone"}, nDone,      1);
        if (expDoneCyc > 0) check({tag, "_donecycle"}, doneCyc, expDoneCyc);
        check({tag, "_overrun"},   nOvr,       expOvr);
        check({tag, "_badbins"},   badBins,    0);
        check({tag, "_stall"},     stallErr,   0);
        check({tag, "_clraddr"},   clrAddrErr, 0);
        check({tag, "_ramclean"},  nz,         0);
    endtask

    initial begin
        bit found;
        int nz;
        rst_n    = 1'b0;
        VSYNC    = 1'b0;
        BinReady = 1'b0;
        set_preload(1'b0);
        load_mem();
        build_exp();
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset_outputs");
        rst_n = 1'b1;

        // 1: ready tied high, exact timing and values.
        run_sweep(1'b0, -1, 1'b0, 1'b1);
        check_sweep("t1", 0, 3 * NBINS + 1);

        // 2: pseudo-random back-pressure.
        set_preload(1'b0); load_mem(); build_exp();
        run_sweep(1'b1, -1, 1'b0, 1'b0);
        check_sweep("t2", 0, -1);

        // 3: second VSYNC rise while bin 100 is presented.
        set_preload(1'b0); load_mem(); build_exp();
        run_sweep(1'b0, 100, 1'b0, 1'b0);
        check_sweep("t3", 1, 3 * NBINS + 1);

        // 6: VSYNC held high through the whole sweep.
        set_preload(1'b0); load_mem(); build_exp();
        run_sweep(1'b0, -1, 1'b1, 1'b0);
        check_sweep("t6", 0, 3 * NBINS + 1);

        // 4: reset while bin 4 is presented and stalled.
        set_preload(1'b0); load_mem(); build_exp();
        @(negedge clk); VSYNC = 1'b0; BinReady = 1'b0;
        @(negedge clk); VSYNC = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            BinReady = 1'b0;
            if (c == 3) VSYNC = 1'b0;
            #1;
            if (BinValid) begin
                if (BinIndex == 4) found = 1'b1;
                else BinReady = 1'b1;
            end
        end
        check("t4_reach_bin4", found, 1);
        check("t4_bin4_count", BinCount, expCnt[4]);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_idle("t4_reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t4_no_framedone", {FrameDone, Busy}, 0);
        nz = 0;
        for (int i = 0; i < 4; i++) if (mem[i] !== '0) nz++;
        check("t4_bins0to3_cleared", nz, 0);
        check("t4_bin4_kept", mem[4], 2);
        check("t4_bin5_kept", mem[5], 3);
        check("t4_bin6_kept", mem[6], 4);
        for (int i = 0; i < 4; i++) pre[i] = '0;
        build_exp();
        run_sweep(1'b0, -1, 1'b0, 1'b1);
        check_sweep("t4b", 0, 3 * NBINS + 1);

        // 5: full-scale bin followed by a small one (saturation in CDF build).
        set_preload(1'b1); load_mem(); build_exp();
        run_sweep(1'b0, -1, 1'b0, 1'b1);
        check_sweep("t5", 0, 3 * NBINS + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
